divider_share_ctrl: RTL and testbench

- Round-robin controller that time-shares one divider_NbyM (16/8, St/Ready handshake, V overflow flag) among NCH requesters.
- Per channel: latches operands at grant, pulses St, waits for completion, returns Quotient/Remainder/V with a one-cycle done strobe.
- Adds a watchdog so a hung divider cannot lock the arbiter.
- Sits between the divider and client blocks in the datapath.

---
 rtl/divider_share_pkg.sv | 27 ++
 rtl/divider_share_if.sv | 43 ++++
 rtl/rr_arbiter_nch.sv | 29 ++
 rtl/divider_share_ctrl.sv | 133 +++++++++++++
 tb/tb_divider_share_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/divider_share_pkg.sv
// Shared widths, FSM encoding and sizing helpers for the
// round-robin divider sharing controller.
package divider_share_pkg;

    localparam int NCH_DEF     = 4;
    localparam int DVEND_W_DEF = 16;
    localparam int DVSOR_W_DEF = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int wd_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

    function automatic int idx_width(input int nch);
        return (nch > 2) ? $clog2(nch) : 1;
    endfunction

    localparam int WD_W_DEF = wd_width(TIMEOUT_DEF);

endpackage

// File: rtl/divider_share_if.sv
// Client-side and divider-side signal bundle of the controller.
// master = controller view, slave = clients/divider view.
interface divider_share_if
    import divider_share_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int DVEND_W = DVEND_W_DEF,
    parameter int DVSOR_W = DVSOR_W_DEF
);
    logic [NCH-1:0]         req;
    logic [NCH*DVEND_W-1:0] dividend_in;
    logic [NCH*DVSOR_W-1:0] divisor_in;
    logic [NCH-1:0]         gnt;
    logic [NCH-1:0]         done;
    logic [DVSOR_W-1:0]     quotient;
    logic [DVSOR_W-1:0]     remainder;
    logic                   v;
    logic                   err;
    logic                   busy;

    logic                   div_st;
    logic [DVEND_W-1:0]     div_dividend;
    logic [DVSOR_W-1:0]     div_divisor;
    logic                   div_v;
    logic                   div_ready;
    logic [DVSOR_W-1:0]     div_quotient;
    logic [DVSOR_W-1:0]     div_remainder;

    modport master (
        input  req, dividend_in, divisor_in,
        input  div_v, div_ready, div_quotient, div_remainder,
        output gnt, done, quotient, remainder, v, err, busy,
        output div_st, div_dividend, div_divisor
    );

    modport slave (
        output req, dividend_in, divisor_in,
        output div_v, div_ready, div_quotient, div_remainder,
        input  gnt, done, quotient, remainder, v, err, busy,
        input  div_st, div_dividend, div_divisor
    );

endinterface

// File: rtl/rr_arbiter_nch.sv
// Combinational round-robin pick: first set req bit at or
// above ptr, wrapping modulo NCH.
module rr_arbiter_nch #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  idx
);

    int c;

    // Scan from farthest offset down so the nearest one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        c     = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            c = (int'(ptr) + i) % NCH;
            if (req[c]) begin
                grant = NCH'(1) << c;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/divider_share_ctrl.sv
// Time-shares one St/Ready divider among NCH requesters with
// round-robin arbitration and a watchdog on the divider.
module divider_share_ctrl
    import divider_share_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int DVEND_W = DVEND_W_DEF,
    parameter int DVSOR_W = DVSOR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic clk,
    input logic rst,
    divider_share_if.master bus
);

    localparam int IW  = idx_width(NCH);
    localparam int WDW = wd_width(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IW-1:0]  LAST_CH = IW'(NCH - 1);

    state_t             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      cur;
    logic [IW-1:0]      win_idx;
    logic [NCH-1:0]     win_gnt;
    logic               ready_q;
    logic [WDW-1:0]     wd;
    logic               cmpl;

    logic [NCH-1:0]     gnt_r;
    logic [NCH-1:0]     done_r;
    logic [DVSOR_W-1:0] quot_r;
    logic [DVSOR_W-1:0] rem_r;
    logic               v_r;
    logic               err_r;
    logic               st_r;
    logic [DVEND_W-1:0] dvd_r;
    logic [DVSOR_W-1:0] dvs_r;

    logic [DVEND_W-1:0] dvd_sel;
    logic [DVSOR_W-1:0] dvs_sel;

    rr_arbiter_nch #(
        .NCH (NCH),
        .IW  (IW)
    ) u_arb (
        .req   (bus.req),
        .ptr   (ptr),
        .grant (win_gnt),
        .idx   (win_idx)
    );

    assign dvd_sel = bus.dividend_in[int'(win_idx)*DVEND_W +: DVEND_W];
    assign dvs_sel = bus.divisor_in[int'(win_idx)*DVSOR_W +: DVSOR_W];

    // Ready rising edge marks the end of the divider operation.
    assign cmpl = !ready_q && bus.div_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cur     <= '0;
            ready_q <= 1'b1;
            wd      <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            quot_r  <= '0;
            rem_r   <= '0;
            v_r     <= 1'b0;
            err_r   <= 1'b0;
            st_r    <= 1'b0;
            dvd_r   <= '0;
            dvs_r   <= '0;
        end else begin
            ready_q <= bus.div_ready;
            gnt_r   <= '0;
            done_r  <= '0;
            st_r    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|bus.req && bus.div_ready) begin
                        cur   <= win_idx;
                        gnt_r <= win_gnt;
                        dvd_r <= dvd_sel;
                        dvs_r <= dvs_sel;
                        state <= START;
                    end
                end
                START: begin
                    st_r  <= 1'b1;
                    wd    <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    if (cmpl) begin
                        quot_r <= bus.div_quotient;
                        rem_r  <= bus.div_remainder;
                        v_r    <= bus.div_v;
                        err_r  <= 1'b0;
                        done_r <= NCH'(1) << cur;
                        state  <= DONE;
                    end else if (wd == WD_LAST) begin
                        quot_r <= '0;
                        rem_r  <= '0;
                        v_r    <= 1'b0;
                        err_r  <= 1'b1;
                        done_r <= NCH'(1) << cur;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= (cur == LAST_CH) ? '0 : cur + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt          = gnt_r;
    assign bus.done         = done_r;
    assign bus.quotient     = quot_r;
    assign bus.remainder    = rem_r;
    assign bus.v            = v_r;
    assign bus.err          = err_r;
    assign bus.busy         = (state != IDLE);
    assign bus.div_st       = st_r;
    assign bus.div_dividend = dvd_r;
    assign bus.div_divisor  = dvs_r;

endmodule

// File: tb/tb_divider_share_ctrl.sv
// Scoreboard bench for divider_share_ctrl with a behavioural
// St/Ready divider that can be made to hang.
module tb_divider_share_ctrl;

    localparam int NCH  = 4;
    localparam int DW   = 16;
    localparam int SW   = 8;
    localparam int TO   = 64;
    localparam int DLAT = 8;
    localparam int BND  = 300;

    typedef struct {
        int         ch;
        logic [7:0] q;
        logic [7:0] r;
        logic       v;
        logic       err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divider_share_if #(.NCH(NCH), .DVEND_W(DW), .DVSOR_W(SW)) bus();

    divider_share_ctrl #(
        .NCH(NCH), .DVEND_W(DW), .DVSOR_W(SW), .TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   st_cyc = 0;
    int   rise_cyc = 0;
    int   ngnt = 0;
    logic outstanding = 1'b0;
    logic hang = 1'b0;
    exp_t sb[$];
    exp_t em;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {v, q, r} as the stub divider produces them
    function automatic logic [16:0] div_ref(input logic [15:0] a,
                                            input logic [7:0] b);
        logic [15:0] qq;
        logic [15:0] rr;
        if (b == 8'd0) return {1'b1, 8'hFF, a[7:0]};
        qq = a / {8'd0, b};
        rr = a % {8'd0, b};
        return {(qq > 16'd255), qq[7:0], rr[7:0]};
    endfunction

    function automatic logic [63:0] outs();
        return {12'd0, bus.gnt, bus.done, bus.quotient, bus.remainder,
                bus.v, bus.err, bus.busy, bus.div_st,
                bus.div_dividend, bus.div_divisor};
    endfunction

    // Behavioural divider, deliberately not reset by rst
    logic        d_ready = 1'b1;
    logic        d_prev = 1'b1;
    logic        d_v = 1'b0;
    logic [7:0]  d_q = 8'd0;
    logic [7:0]  d_r = 8'd0;
    logic [15:0] da = 16'd0;
    logic [7:0]  db = 8'd0;
    int          dcnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (d_ready) begin
            if (bus.div_st) begin
                d_ready <= 1'b0;
                dcnt    <= DLAT;
                da      <= bus.div_dividend;
                db      <= bus.div_divisor;
            end
        end else if (!hang) begin
            if (dcnt == 0) begin
                d_ready <= 1'b1;
                {d_v, d_q, d_r} <= div_ref(da, db);
            end else begin
                dcnt <= dcnt - 1;
            end
        end
    end

    assign bus.div_ready     = d_ready;
    assign bus.div_v         = d_v;
    assign bus.div_quotient  = d_q;
    assign bus.div_remainder = d_r;

    always @(negedge clk) begin
        if (rst) begin
            outstanding = 1'b0;
        end else begin
            if (bus.gnt != '0) begin
                check("gnt_onehot", $countones(bus.gnt), 1);
                check("gnt_while_busy", outstanding, 0);
                outstanding = 1'b1;
                gnt_cyc = cyc;
                ngnt++;
            end
            if (bus.div_st) begin
                check("st_lat", cyc - gnt_cyc, 1);
                st_cyc = cyc;
            end
            if (bus.done != '0) begin
                check("done_onehot", $countones(bus.done), 1);
                if (sb.size() == 0) begin
                    check("unexpected_done", bus.done, 0);
                end else begin
                    em = sb.pop_front();
                    check("done_ch", bus.done, 64'd1 << em.ch);
                    check("quotient", bus.quotient, em.q);
                    check("remainder", bus.remainder, em.r);
                    check("v", bus.v, em.v);
                    check("err", bus.err, em.err);
                    if (em.err) check("wd_lat", cyc - st_cyc, TO);
                end
                outstanding = 1'b0;
            end
        end
        if (d_ready && !d_prev) rise_cyc = cyc;
        d_prev = d_ready;
    end

    task automatic push_exp(input int ch, input logic [15:0] a,
                            input logic [7:0] b, input logic hung);
        exp_t e;
        logic [16:0] rv;
        rv    = div_ref(a, b);
        e.ch  = ch;
        e.v   = hung ? 1'b0 : rv[16];
        e.q   = hung ? 8'd0 : rv[15:8];
        e.r   = hung ? 8'd0 : rv[7:0];
        e.err = hung;
        sb.push_back(e);
    endtask

    task automatic set_ops(input int ch, input logic [15:0] a,
                           input logic [7:0] b);
        bus.dividend_in[ch*DW +: DW] = a;
        bus.divisor_in[ch*SW +: SW]  = b;
    endtask

    task automatic wait_gnt(input int ch, output int lat);
        lat = 0;
        while (!bus.gnt[ch] && lat < BND) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.gnt[ch]) check("gnt_timeout", ch, 99);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < BND) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic run_op(input int ch, input logic [15:0] a,
                          input logic [7:0] b, input logic hung,
                          output int lat);
        push_exp(ch, a, b, hung);
        set_ops(ch, a, b);
        bus.req[ch] = 1'b1;
        wait_gnt(ch, lat);
        bus.req[ch] = 1'b0;
        wait_empty();
    endtask

    initial begin
        int lat;
        int n;
        int base;
        int rst_cyc;
        bus.req         = '0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_op(0, 16'd40000, 8'd200, 1'b0, lat);
        check("gnt_latency", lat, 2);
        run_op(2, 16'd1300, 8'd250, 1'b0, lat);
        run_op(1, 16'd777, 8'd7, 1'b0, lat);
        run_op(0, 16'd10, 8'd0, 1'b0, lat);
        run_op(3, 16'd65280, 8'd255, 1'b0, lat);

        // Pointer is back at 0: all four held high
        for (int k = 0; k < NCH; k++)
            set_ops(k, 16'(1000 + 37 * k), 8'(10 + k));
        for (int rnd = 0; rnd < 2; rnd++)
            for (int k = 0; k < NCH; k++)
                push_exp(k, 16'(1000 + 37 * k), 8'(10 + k), 1'b0);
        base = ngnt;
        bus.req = '1;
        n = 0;
        while (ngnt < base + 8 && n < 4 * BND) begin
            @(negedge clk);
            n++;
        end
        bus.req = '0;
        check("fair_gnt_count", ngnt - base, 8);
        wait_empty();

        hang = 1'b1;
        run_op(1, 16'd500, 8'd5, 1'b1, lat);
        hang = 1'b0;

        set_ops(2, 16'd100, 8'd3);
        bus.req[2] = 1'b1;
        wait_gnt(2, lat);
        bus.req[2] = 1'b0;
        n = 0;
        while (!bus.div_st && n < BND) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_outs", outs(), 0);
        rst_cyc = cyc;
        @(negedge clk);
        rst = 1'b0;

        push_exp(0, 16'd900, 8'd9, 1'b0);
        set_ops(0, 16'd900, 8'd9);
        bus.req[0] = 1'b1;
        wait_gnt(0, lat);
        bus.req[0] = 1'b0;
        check("ready_after_rst", rise_cyc > rst_cyc, 1);
        check("gnt_after_ready", cyc, rise_cyc + 1);
        wait_empty();

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
